fifo_sync_param: RTL and testbench

//   Parametrised single-clock FIFO with internal storage, exact occupancy count,

---
 rtl/fifo_sync_param.sv | 128 ++++++++++++
 tb/tb_fifo_sync_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
//   Single-clock FIFO that buffers data words between a producer stage and a
//   consumer stage. It holds 2**ADDR_WIDTH words and reports an exact
//   occupancy count. It also raises almost-full and almost-empty flags at
//   levels set by parameters. Overflow and underflow error flags are sticky.
//   A push and a pop may be accepted in the same cycle at any fill level.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous, active-low reset
//   push         : write request; data_in is sampled on the same edge
//   data_in      : write data
//   pop          : read request
//   err_clr      : clears overflow/underflow on the next edge
//   data_out     : registered read data, updated one edge after an accepted pop
//   data_valid   : high for the cycle in which data_out carries a new word
//   count        : occupancy, 0..DEPTH
//   full_fifo    : count == DEPTH
//   empty_fifo   : count == 0
//   almost_full  : count >= ALMOST_FULL_LVL
//   almost_empty : count <= ALMOST_EMPTY_LVL
//   overflow     : sticky, a push was rejected since the last clear
//   underflow    : sticky, a pop was rejected since the last clear
//   error        : overflow | underflow
// ---------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int DATA_WIDTH       = 10,
  parameter int ADDR_WIDTH       = 3,
  parameter int ALMOST_FULL_LVL  = 6,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full_fifo,
  output logic                  empty_fifo,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  error
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL  = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0] AE_LVL  = CW'(ALMOST_EMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  // There is no bypass path, so a pop on an empty FIFO is always rejected.
  // A push at full is accepted only when a pop frees a slot on the same edge.
  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ((count != DEPTH_C) | pop_ok);

  // Storage has no reset. The pointers alone decide which entries are live.
  // Writes are held off during reset so that reset discards the stream
  // cleanly.
  always_ff @(posedge clk) begin
    if (reset && push_ok)
      mem[wr_ptr] <= data_in;
  end

  // Pointers, count, read register and sticky errors.
  // The read uses the pre-edge contents of mem. A read and a write to the
  // same slot on one edge therefore return the old word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;

      if (pop_ok) begin
        data_out   <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
        data_valid <= 1'b1;
      end else begin
        data_valid <= 1'b0;
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A new error event in the same cycle as err_clr keeps its flag set.
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;

      if (pop && !pop_ok)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
    end
  end

  // The flags are decoded straight from the count register.
  // This makes them move on the same edge as count.
  assign full_fifo    = (count == DEPTH_C);
  assign empty_fifo   = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign error        = overflow | underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
//   Directed bench for fifo_sync_param (DEPTH=8, DATA_WIDTH=10, levels 6/1).
//   Inputs change on the falling edge. Outputs are sampled 1ns after the
//   rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

  logic       clk;
  logic       reset;
  logic       push;
  logic [9:0] data_in;
  logic       pop;
  logic       err_clr;
  logic [9:0] data_out;
  logic       data_valid;
  logic [3:0] count;
  logic       full_fifo;
  logic       empty_fifo;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;
  logic       error;

  int compared   = 0;
  int mismatched = 0;

  logic [9:0] exp_q[$];
  logic [9:0] exp_word;

  fifo_sync_param #(
    .DATA_WIDTH(10),
    .ADDR_WIDTH(3),
    .ALMOST_FULL_LVL(6),
    .ALMOST_EMPTY_LVL(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .push(push),
    .data_in(data_in),
    .pop(pop),
    .err_clr(err_clr),
    .data_out(data_out),
    .data_valid(data_valid),
    .count(count),
    .full_fifo(full_fifo),
    .empty_fifo(empty_fifo),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs on the falling edge.
  // Returns 1ns after the next rising edge, ready for sampling.
  task automatic applyStimulus(input logic p, input logic [9:0] d,
                               input logic r, input logic c);
    @(negedge clk);
    push    = p;
    data_in = d;
    pop     = r;
    err_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    push    = 1'b0;
    data_in = '0;
    pop     = 1'b0;
    err_clr = 1'b0;

    // Hold reset low for two cycles.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty_fifo, 1);
    checkOutput("rst_aempty", almost_empty, 1);
    checkOutput("rst_full", full_fifo, 0);
    checkOutput("rst_afull", almost_full, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_dout", data_out, 0);
    checkOutput("rst_dvalid", data_valid, 0);
    @(negedge clk);
    reset = 1'b1;

    // Fill with 0x001..0x008 and watch the flag thresholds.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 10'(i), 0, 0);
      checkOutput($sformatf("fill_count%0d", i), count, i);
      checkOutput($sformatf("fill_aempty%0d", i), almost_empty, (i <= 1));
      checkOutput($sformatf("fill_afull%0d", i), almost_full, (i >= 6));
      checkOutput($sformatf("fill_full%0d", i), full_fifo, (i == 8));
      checkOutput($sformatf("fill_empty%0d", i), empty_fifo, 0);
    end

    // A lone push at full is rejected.
    applyStimulus(1, 10'h3FF, 0, 0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_count", count, 8);
    checkOutput("ovf_error", error, 1);

    // Push and pop together at full. Both are accepted.
    applyStimulus(1, 10'h3FF, 1, 0);
    checkOutput("fullpp_count", count, 8);
    checkOutput("fullpp_dvalid", data_valid, 1);
    checkOutput("fullpp_dout", data_out, 10'h001);
    checkOutput("fullpp_ovf_sticky", overflow, 1);

    // Drain. Expect 0x002..0x008 and then 0x3FF.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput($sformatf("drain_dout%0d", i), data_out,
                  (i < 7) ? 10'(i + 2) : 10'h3FF);
      checkOutput($sformatf("drain_count%0d", i), count, 7 - i);
      checkOutput($sformatf("drain_dvalid%0d", i), data_valid, 1);
    end
    checkOutput("drain_empty", empty_fifo, 1);

    // Pop on empty is rejected and data_out holds its last value.
    applyStimulus(0, 0, 1, 0);
    checkOutput("udf_flag", underflow, 1);
    checkOutput("udf_dvalid", data_valid, 0);
    checkOutput("udf_dout_hold", data_out, 10'h3FF);
    checkOutput("udf_count", count, 0);

    // err_clr clears both sticky flags.
    applyStimulus(0, 0, 0, 1);
    checkOutput("clr_error", error, 0);
    checkOutput("clr_ovf", overflow, 0);
    checkOutput("clr_udf", underflow, 0);

    // A new error in the err_clr cycle keeps its flag set.
    applyStimulus(0, 0, 1, 1);
    checkOutput("clrwin_udf", underflow, 1);
    checkOutput("clrwin_ovf", overflow, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("clrwin_cleared", error, 0);

    // No bypass: push and pop on empty accepts the push and rejects the pop.
    applyStimulus(1, 10'h055, 1, 0);
    checkOutput("nobyp_count", count, 1);
    checkOutput("nobyp_dvalid", data_valid, 0);
    checkOutput("nobyp_udf", underflow, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("nobyp_dout", data_out, 10'h055);
    checkOutput("nobyp_dvalid2", data_valid, 1);
    checkOutput("nobyp_clr", error, 0);

    // 20 interleaved cycles crossing the pointer wrap, checked against a
    // queue scoreboard.
    for (int i = 0; i < 20; i++) begin
      logic p, r, pok, rok;
      p   = (i % 3) != 2;
      r   = (i % 4) == 1 || (i % 4) == 3 || i >= 14;
      rok = r && (exp_q.size() != 0);
      pok = p && ((exp_q.size() != 8) || rok);
      if (rok) exp_word = exp_q.pop_front();
      if (pok) exp_q.push_back(10'h100 + 10'(i));
      applyStimulus(p, 10'h100 + 10'(i), r, 0);
      checkOutput($sformatf("mix_count%0d", i), count, exp_q.size());
      checkOutput($sformatf("mix_dvalid%0d", i), data_valid, rok);
      if (rok)
        checkOutput($sformatf("mix_dout%0d", i), data_out, exp_word);
    end

    // Empty whatever remains, then set up count = 5.
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      exp_word = exp_q.pop_front();
      applyStimulus(0, 0, 1, 0);
      checkOutput($sformatf("tail_dout%0d", i), data_out, exp_word);
    end
    checkOutput("tail_empty", empty_fifo, 1);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 10'h200 + 10'(i), 0, 0);
    checkOutput("pre_rst_count", count, 5);

    // Reset mid-operation with a pop pending. Nothing may complete.
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 1, 0);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_empty", empty_fifo, 1);
    checkOutput("midrst_dvalid", data_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 1, 0);
    checkOutput("postrst_udf", underflow, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
